// File: rtl/regfile_bypass_if.sv
// Bus bundle for regfile_bypass: read/write/claim requests toward the register file
// and registered read results back.
interface regfile_bypass_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 3
);
  logic              re;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic              we;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] dataIn;
  logic              claim_en;
  logic [ADDR_W-1:0] claim_rd;
  logic [DATA_W-1:0] dataOutA;
  logic [DATA_W-1:0] dataOutB;
  logic              busyA;
  logic              busyB;
  logic              rvalid;

  modport master (
    output re, rs, rt, we, rd, dataIn, claim_en, claim_rd,
    input  dataOutA, dataOutB, busyA, busyB, rvalid
  );

  modport slave (
    input  re, rs, rt, we, rd, dataIn, claim_en, claim_rd,
    output dataOutA, dataOutB, busyA, busyB, rvalid
  );
endinterface

// File: rtl/regfile_bypass.sv
// Two-read/one-write register file with per-register busy scoreboard bits,
// write-through bypass on reads and an optional hard-wired zero register.
module regfile_bypass #(
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  regfile_bypass_if.slave  bus
);
  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [NREG];
  logic [NREG-1:0]   r_busy;
  logic [DATA_W-1:0] r_data_a_p1;
  logic [DATA_W-1:0] r_data_b_p1;
  logic              r_busy_a_p1;
  logic              r_busy_b_p1;
  logic              r_vld_p1;

  logic              w_wr_ok;
  logic              w_claim_ok;
  logic [DATA_W:0]   w_rd_a;
  logic [DATA_W:0]   w_rd_b;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  assign w_wr_ok    = bus.we && !is_zero_reg(bus.rd);
  assign w_claim_ok = bus.claim_en && !is_zero_reg(bus.claim_rd);

  // Read-port selection as {busy, data}; a same-cycle write forwards its data with busy clear
  always_comb begin
    w_rd_a = {r_busy[bus.rs], r_mem[bus.rs]};
    w_rd_b = {r_busy[bus.rt], r_mem[bus.rt]};
    if (w_wr_ok && (bus.rs == bus.rd)) w_rd_a = {1'b0, bus.dataIn};
    if (w_wr_ok && (bus.rt == bus.rd)) w_rd_b = {1'b0, bus.dataIn};
    if (is_zero_reg(bus.rs)) w_rd_a = '0;
    if (is_zero_reg(bus.rt)) w_rd_b = '0;
  end

  // Stage p1: storage update and registered read results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
      r_busy      <= '0;
      r_data_a_p1 <= '0;
      r_data_b_p1 <= '0;
      r_busy_a_p1 <= 1'b0;
      r_busy_b_p1 <= 1'b0;
      r_vld_p1    <= 1'b0;
    end else begin
      if (w_wr_ok) r_mem[bus.rd] <= bus.dataIn;
      // Claim is the younger instruction, so it overrides a same-cycle write's clear
      for (int i = 0; i < NREG; i++) begin
        if (w_claim_ok && (bus.claim_rd == ADDR_W'(i)))
          r_busy[i] <= 1'b1;
        else if (w_wr_ok && (bus.rd == ADDR_W'(i)))
          r_busy[i] <= 1'b0;
      end
      r_vld_p1 <= bus.re;
      if (bus.re) begin
        r_data_a_p1 <= w_rd_a[DATA_W-1:0];
        r_busy_a_p1 <= w_rd_a[DATA_W];
        r_data_b_p1 <= w_rd_b[DATA_W-1:0];
        r_busy_b_p1 <= w_rd_b[DATA_W];
      end
    end
  end

  assign bus.dataOutA = r_data_a_p1;
  assign bus.dataOutB = r_data_b_p1;
  assign bus.busyA    = r_busy_a_p1;
  assign bus.busyB    = r_busy_b_p1;
  assign bus.rvalid   = r_vld_p1;
endmodule

// File: tb/tb_regfile_bypass.sv
// Scoreboard bench for regfile_bypass: a behavioural register-file model predicts
// each read result at issue time; results are popped and compared when rvalid is due.
module tb_regfile_bypass;
  localparam int DW = 24;
  localparam int AW = 3;

  typedef struct {
    logic          re;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          we;
    logic [AW-1:0] rd;
    logic [DW-1:0] din;
    logic          cl;
    logic [AW-1:0] crd;
  } stim_t;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          ba;
    logic          bb;
  } exp_t;

  logic clk;
  logic rst;
  regfile_bypass_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_bypass #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  logic [DW-1:0] m_mem [8];
  logic [7:0]    m_busy;
  exp_t          q[$];
  exp_t          last;

  function automatic stim_t mk(input logic re, input int rs, input int rt,
                               input logic we, input int rd, input logic [DW-1:0] din,
                               input logic cl, input int crd);
    stim_t s;
    s.re = re; s.rs = AW'(rs); s.rt = AW'(rt);
    s.we = we; s.rd = AW'(rd); s.din = din;
    s.cl = cl; s.crd = AW'(crd);
    return s;
  endfunction

  function automatic logic [DW:0] predict(input logic [AW-1:0] a, input stim_t s);
    if (a == 0) return '0;
    if (s.we && s.rd != 0 && s.rd == a) return {1'b0, s.din};
    return {m_busy[a], m_mem[a]};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    m_busy = '0;
    q.delete();
    last = '0;
  endfunction

  // Drive one cycle of stimulus, enqueue the predicted read result, then advance the model
  task automatic issue(input stim_t s);
    logic [DW:0] pa, pb;
    exp_t e;
    bus.re = s.re; bus.rs = s.rs; bus.rt = s.rt;
    bus.we = s.we; bus.rd = s.rd; bus.dataIn = s.din;
    bus.claim_en = s.cl; bus.claim_rd = s.crd;
    if (s.re) begin
      pa = predict(s.rs, s);
      pb = predict(s.rt, s);
      e.a = pa[DW-1:0]; e.ba = pa[DW];
      e.b = pb[DW-1:0]; e.bb = pb[DW];
      q.push_back(e);
    end
    if (s.we && s.rd != 0) begin
      m_mem[s.rd]  = s.din;
      m_busy[s.rd] = 1'b0;
    end
    if (s.cl && s.crd != 0) m_busy[s.crd] = 1'b1;
  endtask

  task automatic test_reset();
    stim_t s[$];
    logic exp_rv;
    nchk++;
    if ({bus.dataOutA, bus.dataOutB, bus.busyA, bus.busyB, bus.rvalid} !== '0) begin
      nerr++;
      $display("FAIL reset_state: got %h expected 0",
               {bus.dataOutA, bus.dataOutB, bus.busyA, bus.busyB, bus.rvalid});
    end
    rst = 1'b0;
    s.push_back(mk(1, 3, 5, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[k]) begin
      issue(s[k]);
      @(posedge clk); #1;
      exp_rv = (q.size() != 0);
      nchk++;
      if (bus.rvalid !== exp_rv) begin
        nerr++; $display("FAIL reset_rvalid[%0d]: got %b expected %b", k, bus.rvalid, exp_rv);
      end
      if (exp_rv) last = q.pop_front();
      nchk++;
      if ({bus.dataOutA, bus.dataOutB, bus.busyA, bus.busyB} !== last) begin
        nerr++; $display("FAIL reset_read[%0d]: got %h expected %h", k,
                         {bus.dataOutA, bus.dataOutB, bus.busyA, bus.busyB}, last);
      end
    end
  endtask

  task automatic test_write_read();
    stim_t s[$];
    logic exp_rv;
    s.push_back(mk(0, 0, 0, 1, 2, 24'hABCDEF, 0, 0));
    s.push_back(mk(1, 2, 3, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(1, 4, 4, 1, 4, 24'h123456, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[k]) begin
      issue(s[k]);
      @(posedge clk); #1;
      exp_rv = (q.size() != 0);
      nchk++;
      if (bus.rvalid !== exp_rv) begin
        nerr++; $display("FAIL wr_rvalid[%0d]: got %b expected %b", k, bus.rvalid, exp_rv);
      end
      if (exp_rv) last = q.pop_front();
      nchk++;
      if ({bus.dataOutA, bus.dataOutB, bus.busyA, bus.busyB} !== last) begin
        nerr++; $display("FAIL wr_read[%0d]: got %h expected %h", k,
                         {bus.dataOutA, bus.dataOutB, bus.busyA, bus.busyB}, last);
      end
      if (k == 1) begin
        nchk++;
        if (bus.dataOutA !== 24'hABCDEF) begin
          nerr++; $display("FAIL wr_abcdef: got %h expected abcdef", bus.dataOutA);
        end
      end
      if (k == 4) begin
        nchk++;
        if ({bus.dataOutA, bus.dataOutB} !== {24'h123456, 24'h123456}) begin
          nerr++; $display("FAIL bypass_hold: got %h/%h expected 123456/123456",
                           bus.dataOutA, bus.dataOutB);
        end
      end
    end
  endtask

  task automatic test_zero_reg();
    stim_t s[$];
    logic exp_rv;
    s.push_back(mk(1, 0, 0, 1, 0, 24'hFFFFFF, 1, 0));
    s.push_back(mk(1, 0, 2, 0, 0, 0, 0, 0));
    foreach (s[k]) begin
      issue(s[k]);
      @(posedge clk); #1;
      exp_rv = (q.size() != 0);
      nchk++;
      if (bus.rvalid !== exp_rv) begin
        nerr++; $display("FAIL zero_rvalid[%0d]: got %b expected %b", k, bus.rvalid, exp_rv);
      end
      if (exp_rv) last = q.pop_front();
      nchk++;
      if ({bus.dataOutA, bus.dataOutB, bus.busyA, bus.busyB} !== last) begin
        nerr++; $display("FAIL zero_read[%0d]: got %h expected %h", k,
                         {bus.dataOutA, bus.dataOutB, bus.busyA, bus.busyB}, last);
      end
    end
    nchk++;
    if ({bus.dataOutA, bus.busyA} !== '0) begin
      nerr++; $display("FAIL zero_const: got %h/%b expected 0/0", bus.dataOutA, bus.busyA);
    end
  endtask

  task automatic test_claim();
    stim_t s[$];
    logic exp_rv;
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 6));
    s.push_back(mk(1, 6, 6, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 6, 24'h0A0B0C, 1, 6));
    s.push_back(mk(1, 6, 1, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 6, 24'h111111, 0, 0));
    s.push_back(mk(1, 6, 6, 0, 0, 0, 0, 0));
    s.push_back(mk(1, 7, 6, 0, 0, 0, 1, 7));
    s.push_back(mk(1, 7, 7, 0, 0, 0, 1, 7));
    s.push_back(mk(1, 5, 7, 1, 5, 24'h555AAA, 1, 5));
    s.push_back(mk(1, 5, 5, 0, 0, 0, 0, 0));
    foreach (s[k]) begin
      issue(s[k]);
      @(posedge clk); #1;
      exp_rv = (q.size() != 0);
      nchk++;
      if (bus.rvalid !== exp_rv) begin
        nerr++; $display("FAIL claim_rvalid[%0d]: got %b expected %b", k, bus.rvalid, exp_rv);
      end
      if (exp_rv) last = q.pop_front();
      nchk++;
      if ({bus.dataOutA, bus.dataOutB, bus.busyA, bus.busyB} !== last) begin
        nerr++; $display("FAIL claim_read[%0d]: got %h expected %h", k,
                         {bus.dataOutA, bus.dataOutB, bus.busyA, bus.busyB}, last);
      end
      if (k == 1 || k == 3) begin
        nchk++;
        if (bus.busyA !== 1'b1) begin
          nerr++; $display("FAIL claim_busy6[%0d]: got %b expected 1", k, bus.busyA);
        end
      end
      if (k == 5) begin
        nchk++;
        if (bus.busyA !== 1'b0) begin
          nerr++; $display("FAIL claim_clear6: got %b expected 0", bus.busyA);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    logic exp_rv;
    for (int k = 0; k < 60; k++) begin
      s = mk($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 1) == 1, $urandom_range(0, 7), DW'($urandom),
             $urandom_range(0, 3) == 0, $urandom_range(0, 7));
      issue(s);
      @(posedge clk); #1;
      exp_rv = (q.size() != 0);
      nchk++;
      if (bus.rvalid !== exp_rv) begin
        nerr++; $display("FAIL b2b_rvalid[%0d]: got %b expected %b", k, bus.rvalid, exp_rv);
      end
      if (exp_rv) last = q.pop_front();
      nchk++;
      if ({bus.dataOutA, bus.dataOutB, bus.busyA, bus.busyB} !== last) begin
        nerr++; $display("FAIL b2b_read[%0d]: got %h expected %h", k,
                         {bus.dataOutA, bus.dataOutB, bus.busyA, bus.busyB}, last);
      end
    end
  endtask

  task automatic test_async_reset();
    stim_t s[$];
    logic exp_rv;
    s.push_back(mk(0, 0, 0, 1, 1, 24'h000055, 0, 0));
    s.push_back(mk(1, 1, 1, 0, 0, 0, 1, 1));
    foreach (s[k]) begin
      issue(s[k]);
      @(posedge clk); #1;
      exp_rv = (q.size() != 0);
      if (exp_rv) last = q.pop_front();
      nchk++;
      if ({bus.dataOutA, bus.dataOutB, bus.busyA, bus.busyB, bus.rvalid} !== {last, exp_rv}) begin
        nerr++; $display("FAIL arst_pre[%0d]: got %h expected %h", k,
                         {bus.dataOutA, bus.dataOutB, bus.busyA, bus.busyB, bus.rvalid},
                         {last, exp_rv});
      end
    end
    bus.re = 1'b1; bus.rs = 3'd1; bus.rt = 3'd1;
    bus.we = 1'b0; bus.claim_en = 1'b0;
    #3 rst = 1'b1;
    #1;
    nchk++;
    if ({bus.dataOutA, bus.dataOutB, bus.busyA, bus.busyB, bus.rvalid} !== '0) begin
      nerr++; $display("FAIL arst_immediate: got %h expected 0",
                       {bus.dataOutA, bus.dataOutB, bus.busyA, bus.busyB, bus.rvalid});
    end
    @(posedge clk); #1;
    nchk++;
    if (bus.rvalid !== 1'b0) begin
      nerr++; $display("FAIL arst_rvalid: got %b expected 0", bus.rvalid);
    end
    model_reset();
    rst = 1'b0;
    issue(mk(1, 1, 2, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    last = q.pop_front();
    nchk++;
    if ({bus.dataOutA, bus.dataOutB, bus.busyA, bus.busyB, bus.rvalid} !== {last, 1'b1}) begin
      nerr++; $display("FAIL arst_after: got %h expected %h",
                       {bus.dataOutA, bus.dataOutB, bus.busyA, bus.busyB, bus.rvalid},
                       {last, 1'b1});
    end
    nchk++;
    if (bus.dataOutA !== '0) begin
      nerr++; $display("FAIL arst_reg1: got %h expected 0", bus.dataOutA);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.re = 1'b0; bus.rs = '0; bus.rt = '0;
    bus.we = 1'b0; bus.rd = '0; bus.dataIn = '0;
    bus.claim_en = 1'b0; bus.claim_rd = '0;
    model_reset();
    #12;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_claim();
    test_back_to_back();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/regfile_bypass.md
REGFILE_BYPASS -- requirements
Module: regfile_bypass

Interface
REQ-001 Parameter DATA_W, default 24: register and data-port width in bits.
REQ-002 Parameter ADDR_W, default 3: register address width; register count = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 1: 1 = register 0 reads as zero, ignores writes and never goes busy; 0 = register 0 is ordinary.
REQ-004 clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 re  in  1  read request; samples rs and rt.
REQ-007 rs, rt  in  ADDR_W each  read addresses, ports A and B.
REQ-008 we  in  1  write enable.
REQ-009 rd  in  ADDR_W  write address.
REQ-010 dataIn  in  DATA_W  write data.
REQ-011 claim_en  in  1  marks register claim_rd busy (pending writer issued).
REQ-012 claim_rd  in  ADDR_W  register being claimed.
REQ-013 dataOutA, dataOutB  out  DATA_W each  registered read data.
REQ-014 busyA, busyB  out  1 each  registered busy status of the register read on each port.
REQ-015 rvalid  out  1  high for exactly one cycle when dataOut*/busy* carry a new read result.

Function
REQ-016 Storage: 2**ADDR_W registers of DATA_W bits, plus one busy bit per register.
REQ-017 Write: on a rising edge with we=1, register rd takes dataIn and its busy bit clears, unless ZERO_REG=1 and rd=0 (no effect).
REQ-018 Read latency: one cycle; on a rising edge with re=1, dataOutA/busyA load from rs and dataOutB/busyB load from rt; rvalid=1 in the following cycle.
REQ-019 re=0: dataOut*, busy* hold their previous values; rvalid=0.
REQ-020 Reads and writes are independent: re and we may both be 1 in one cycle and both complete.
REQ-021 Write-through bypass: re=1, we=1, rs=rd (and rd write not suppressed by REQ-017) -> dataOutA loads dataIn and busyA loads 0; same rule for port B with rt.
REQ-022 ZERO_REG=1: a read of address 0 returns 0 and busy 0 regardless of any write or claim to 0.
REQ-023 Claim: on a rising edge with claim_en=1, busy[claim_rd] sets to 1 (suppressed for address 0 when ZERO_REG=1).
REQ-024 Claim and write to the same register in one cycle: data is written, busy ends set (claim wins; it is the newer instruction).
REQ-025 Claim and read of the same register in one cycle: busy* reports the pre-edge status, except REQ-021 bypass applies (write clears, then claim does not affect this read result).
REQ-026 Claim of a register already busy: stays busy; no error output.
REQ-027 Both ports may address the same register; both return identical data/busy.
REQ-028 Addresses wider than needed never occur; all 2**ADDR_W addresses valid; no wrap logic.

Reset
REQ-029 rst=1 asynchronously clears all registers to 0, all busy bits to 0, dataOutA, dataOutB to 0, busyA, busyB, rvalid to 0.
REQ-030 While rst=1, writes, claims and reads are ignored; a read requested in the cycle rst deasserts is performed normally on the next edge.
REQ-031 rst asserted mid-operation (read in flight) suppresses that rvalid pulse.

Verification
REQ-032 Reset then re=1, rs=3, rt=5 -> next cycle dataOutA=0, dataOutB=0, busyA=busyB=0, rvalid=1.
REQ-033 we=1, rd=2, dataIn=0xABCDEF; next cycle re=1, rs=2 -> dataOutA=0xABCDEF one cycle later; rvalid one cycle wide.
REQ-034 Same-cycle we=1, rd=4, dataIn=0x123456 with re=1, rs=4, rt=4 -> dataOutA=dataOutB=0x123456 next cycle (bypass).
REQ-035 ZERO_REG=1: we=1, rd=0, dataIn=0xFFFFFF, claim_en=1, claim_rd=0; then read rs=0 -> dataOutA=0, busyA=0.
REQ-036 claim_en=1, claim_rd=6; read rs=6 -> busyA=1; then we=1, rd=6 with claim_en=1, claim_rd=6 -> subsequent read busyA=1; then we only -> busyA=0.
REQ-037 Write rd=1 data 0x000055, assert rst asynchronously mid-cycle with re=1 pending -> outputs 0 immediately, no rvalid pulse, read rs=1 after release returns 0.
